// File: rtl/uart_rx_shift.sv
// UART receive shift engine: oversamples the RX line, validates the start bit,
// assembles a 5..8 bit character and reports parity/framing/break status.
module uart_rx_shift (
    input  logic       bclk_in,
    input  logic       rstn_in,
    input  logic       enable_in,
    input  logic       serial_in,
    input  logic       osm_sel_in,
    input  logic [1:0] wls_in,
    input  logic       pen_in,
    input  logic       esp_in,
    input  logic       sp_in,
    input  logic       stb_in,
    output logic [7:0] rbr_out,
    output logic       rx_valid_out,
    output logic       pe_out,
    output logic       fe_out,
    output logic       bi_out,
    output logic       busy_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t     state_q, state_d;

    logic       sync1_q;
    logic       rxs_q;
    logic       rxd_q;

    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       dxor_q, dxor_d;
    logic       pbit_q, pbit_d;
    logic       zero_q, zero_d;

    logic       osm_q, osm_d;
    logic [1:0] wls_q, wls_d;
    logic       pen_q, pen_d;
    logic       esp_q, esp_d;
    logic       sp_q, sp_d;

    logic [7:0] rbr_q, rbr_d;
    logic       valid_q, valid_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;

    logic [3:0] bit_last;
    logic [3:0] start_last;
    logic [2:0] data_last;
    logic       bit_tick;
    logic       start_edge;

    // Only the first stop bit is ever checked, so the stop-bit count has no effect here.
    logic       unused_stb;
    assign unused_stb = stb_in;

    function automatic logic parity_err(input logic pen, input logic sp, input logic esp,
                                        input logic data_xor, input logic pbit);
        if (!pen) begin
            return 1'b0;
        end
        if (sp) begin
            return pbit ^ ~esp;
        end
        return data_xor ^ pbit ^ ~esp;
    endfunction

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            rxd_q   <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rxs_q   <= sync1_q;
            rxd_q   <= rxs_q;
        end
    end

    assign bit_last   = osm_q ? 4'd12 : 4'd15;
    // The edge-detect cycle is sample 0, so the counter trails the sample index by one.
    assign start_last = osm_q ? 4'd5 : 4'd6;
    assign data_last  = {1'b1, wls_q};
    assign bit_tick   = (cnt_q == bit_last);
    assign start_edge = rxd_q & ~rxs_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 4'd1;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        dxor_d   = dxor_q;
        pbit_d   = pbit_q;
        zero_d   = zero_q;
        osm_d    = osm_q;
        wls_d    = wls_q;
        pen_d    = pen_q;
        esp_d    = esp_q;
        sp_d     = sp_q;
        rbr_d    = rbr_q;
        valid_d  = 1'b0;
        pe_d     = pe_q;
        fe_d     = fe_q;
        bi_d     = bi_q;

        if (!enable_in) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = 4'd0;
                    if (start_edge) begin
                        state_d  = ST_START;
                        bitcnt_d = 3'd0;
                        shreg_d  = 8'h00;
                        dxor_d   = 1'b0;
                        pbit_d   = 1'b0;
                        zero_d   = 1'b1;
                        osm_d    = osm_sel_in;
                        wls_d    = wls_in;
                        pen_d    = pen_in;
                        esp_d    = esp_in;
                        sp_d     = sp_in;
                    end
                end
                ST_START: begin
                    if (cnt_q == start_last) begin
                        cnt_d   = 4'd0;
                        state_d = rxs_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt_d             = 4'd0;
                        shreg_d[bitcnt_q] = rxs_q;
                        dxor_d            = dxor_q ^ rxs_q;
                        zero_d            = zero_q & ~rxs_q;
                        if (bitcnt_q == data_last) begin
                            state_d = pen_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt_d   = 4'd0;
                        pbit_d  = rxs_q;
                        zero_d  = zero_q & ~rxs_q;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                        valid_d = 1'b1;
                        rbr_d   = shreg_q;
                        fe_d    = ~rxs_q;
                        bi_d    = zero_q & ~rxs_q;
                        pe_d    = parity_err(pen_q, sp_q, esp_q, dxor_q, pbit_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            cnt_q    <= 4'd0;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            dxor_q   <= 1'b0;
            pbit_q   <= 1'b0;
            zero_q   <= 1'b1;
            osm_q    <= 1'b0;
            wls_q    <= 2'b00;
            pen_q    <= 1'b0;
            esp_q    <= 1'b0;
            sp_q     <= 1'b0;
            rbr_q    <= 8'h00;
            valid_q  <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            bi_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            dxor_q   <= dxor_d;
            pbit_q   <= pbit_d;
            zero_q   <= zero_d;
            osm_q    <= osm_d;
            wls_q    <= wls_d;
            pen_q    <= pen_d;
            esp_q    <= esp_d;
            sp_q     <= sp_d;
            rbr_q    <= rbr_d;
            valid_q  <= valid_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            bi_q     <= bi_d;
        end
    end

    assign rbr_out      = rbr_q;
    assign rx_valid_out = valid_q;
    assign pe_out       = pe_q;
    assign fe_out       = fe_q;
    assign bi_out       = bi_q;
    assign busy_out     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_shift.sv
// Bench for uart_rx_shift: table of frames plus glitch/break/abort/back-to-back sequences.
module tb_uart_rx_shift;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       ser = 1'b1;
    logic       osm = 1'b0;
    logic [1:0] wls = 2'b00;
    logic       pen = 1'b0;
    logic       esp = 1'b0;
    logic       sp = 1'b0;
    logic       stb = 1'b0;
    logic [7:0] rbr;
    logic       vld, pe, fe, bi, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_shift dut (
        .bclk_in(clk), .rstn_in(rstn), .enable_in(en), .serial_in(ser),
        .osm_sel_in(osm), .wls_in(wls), .pen_in(pen), .esp_in(esp), .sp_in(sp),
        .stb_in(stb), .rbr_out(rbr), .rx_valid_out(vld), .pe_out(pe),
        .fe_out(fe), .bi_out(bi), .busy_out(busy)
    );

    typedef struct {
        logic       osm;
        logic [1:0] wls;
        logic       pen;
        logic       esp;
        logic       sp;
        logic       stb;
        logic [7:0] data;
        logic       pbit;
        logic       stopb;
        logic [7:0] e_rbr;
        logic       e_pe;
        logic       e_fe;
        logic       e_bi;
        int         lat;   // edges from the line fall to the valid pulse
    } vec_t;

    typedef struct {
        logic [7:0] rbr;
        logic       pe;
        logic       fe;
        logic       bi;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[12];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && vld === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got rbr=%0h with no frame pending (cycle %0d)", rbr, cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("rbr", int'(rbr), int'(mon_e.rbr));
                check("pe", int'(pe), int'(mon_e.pe));
                check("fe", int'(fe), int'(mon_e.fe));
                check("bi", int'(bi), int'(mon_e.bi));
                check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic drive_line(input logic v, input int n);
        @(posedge clk);
        #1 ser = v;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic push_exp(input logic [7:0] r, input logic p, input logic f, input logic b, input int at);
        exp_t e;
        e.rbr = r; e.pe = p; e.fe = f; e.bi = b; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic send_frame(input vec_t v, input int idle);
        int s;
        int n;
        s = v.osm ? 13 : 16;
        n = 5 + int'(v.wls);
        osm = v.osm; wls = v.wls; pen = v.pen; esp = v.esp; sp = v.sp; stb = v.stb;
        if (idle > 0) drive_line(1'b1, idle);
        @(posedge clk);
        #1 ser = 1'b0;
        push_exp(v.e_rbr, v.e_pe, v.e_fe, v.e_bi, cyc + v.lat);
        repeat (s - 1) @(posedge clk);
        for (int k = 0; k < n; k++) drive_line(v.data[k], s);
        if (v.pen) drive_line(v.pbit, s);
        drive_line(v.stopb, s);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 400) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        check("queue_drained", sbq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t c3c;
        vec_t b2b_a;
        vec_t b2b_b;
        //        osm   wls    pen   esp   sp    stb   data   pbit  stop  e_rbr  pe    fe    bi    lat
        vt[0]  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 154};
        vt[1]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 100};
        vt[2]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h13, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 100};
        vt[3]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 154};
        vt[4]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 154};
        vt[5]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEA, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0, 138};
        vt[6]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 126};
        vt[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 106};
        vt[8]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 139};
        vt[9]  = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 170};
        vt[10] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 154};
        vt[11] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h15, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0, 113};
        c3c    = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 154};
        b2b_a  = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 154};
        b2b_b  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 126};

        repeat (3) @(posedge clk);
        #1;
        check("reset_rbr", int'(rbr), 0);
        check("reset_valid", int'(vld), 0);
        check("reset_pe", int'(pe), 0);
        check("reset_fe", int'(fe), 0);
        check("reset_bi", int'(bi), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rstn = 1'b1;
        en = 1'b1;

        for (int i = 0; i < 12; i++) send_frame(vt[i], 4);
        drain();

        // False start: 5-cycle low pulse
        osm = 1'b0; wls = 2'd3; pen = 1'b0;
        drive_line(1'b1, 4);
        drive_line(1'b0, 5);
        #2 check("glitch_busy_high", int'(busy), 1);
        drive_line(1'b1, 30);
        #2 check("glitch_busy_clear", int'(busy), 0);

        // Break: 12 bit-times low at 8N1
        drive_line(1'b1, 4);
        @(posedge clk);
        #1 ser = 1'b0;
        push_exp(8'h00, 1'b0, 1'b1, 1'b1, cyc + 154);
        repeat (191) @(posedge clk);
        #2 check("break_no_retrigger_busy", int'(busy), 0);
        check("break_reported", sbq.size(), 0);
        drive_line(1'b1, 20);

        // Enable dropped during data bit 3 of 0x3C
        drive_line(1'b0, 16);
        drive_line(1'b0, 16);
        drive_line(1'b0, 16);
        drive_line(1'b1, 16);
        drive_line(1'b1, 8);
        #2 check("abort_en_busy_before", int'(busy), 1);
        en = 1'b0;
        drive_line(1'b1, 2);
        #2;
        check("abort_en_busy", int'(busy), 0);
        check("abort_en_rbr_hold", int'(rbr), 0);
        check("abort_en_fe_hold", int'(fe), 1);
        check("abort_en_bi_hold", int'(bi), 1);
        check("abort_en_pe_hold", int'(pe), 0);
        drive_line(1'b1, 20);
        #1 en = 1'b1;
        send_frame(c3c, 4);
        drain();

        // Reset pulsed mid-frame
        drive_line(1'b1, 4);
        drive_line(1'b0, 16);
        drive_line(1'b0, 16);
        #2 check("abort_rst_busy_before", int'(busy), 1);
        rstn = 1'b0;
        ser = 1'b1;
        #1;
        check("abort_rst_rbr", int'(rbr), 0);
        check("abort_rst_fe", int'(fe), 0);
        check("abort_rst_valid", int'(vld), 0);
        check("abort_rst_busy", int'(busy), 0);
        @(negedge clk);
        rstn = 1'b1;
        drive_line(1'b1, 20);
        send_frame(c3c, 4);
        drain();

        // Back-to-back frames, config switched between them
        send_frame(b2b_a, 4);
        send_frame(b2b_b, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
